// File: rtl/mem_responder_if.sv
// Request/response bundle between the memory requester and mem_responder.
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_read;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [3:0]            req_be;
    logic                  req_ready;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic                  busy;

    modport master (
        output req_read, req_write, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_read, req_write, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding request, word-addressed RAM,
// programmable read/write wait states and a one-cycle response pulse.
module mem_responder #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 1024,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    mem_responder_if.slave bus
);
    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);
    localparam logic [CNT_W-1:0]    RD_LOAD    = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0]    WR_LOAD    = CNT_W'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RESPOND
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [IDX_W-1:0] lat_idx;
    logic [31:0]      lat_wdata;
    logic [3:0]       lat_be;
    logic [31:0]      resp_rdata_q;
    logic             resp_err_q;

    logic [31:0]      mem [DEPTH_WORDS];

    logic accept;
    logic misaligned;
    logic out_of_range;
    logic req_bad;
    logic rd_done;
    logic wr_done;

    assign misaligned   = (bus.req_addr[1:0] != 2'b00);
    assign out_of_range = ({1'b0, bus.req_addr} >= ADDR_LIMIT);
    assign req_bad      = (bus.req_read & bus.req_write) | misaligned | out_of_range;
    assign accept       = (state == IDLE) & (bus.req_read | bus.req_write);
    assign rd_done      = (state == RD_WAIT) && (cnt == '0);
    assign wr_done      = (state == WR_WAIT) && (cnt == '0);

    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.resp_valid = (state == RESPOND);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // State and wait-state counter registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: bad requests respond at once, good ones count down their latency.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_nxt = RESPOND;
                    end else if (bus.req_write) begin
                        state_nxt = WR_WAIT;
                        cnt_nxt   = WR_LOAD;
                    end else begin
                        state_nxt = RD_WAIT;
                        cnt_nxt   = RD_LOAD;
                    end
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESPOND;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESPOND: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the request at acceptance and load the response registers on entry to RESPOND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_idx      <= '0;
            lat_wdata    <= '0;
            lat_be       <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                lat_idx   <= bus.req_addr[IDX_W+1:2];
                lat_wdata <= bus.req_wdata;
                lat_be    <= bus.req_be;
                if (req_bad) begin
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b1;
                end
            end
            if (rd_done) begin
                resp_rdata_q <= mem[lat_idx];
                resp_err_q   <= 1'b0;
            end
            if (wr_done) begin
                resp_rdata_q <= '0;
                resp_err_q   <= 1'b0;
            end
        end
    end

    // RAM byte-lane commit on the edge that ends the write wait; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_done) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule
